// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the ID-stage hazard/stall controller: opcode
// constants (common with the ID decoder), FSM state encoding and the
// register-usage decode helpers.
package hazard_stall_ctrl_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // Instruction formats that read rs1 as a source operand.
  function automatic logic uses_rs1(input logic [6:0] opc);
    return (opc == OPC_R) || (opc == OPC_LOAD) ||
           (opc == OPC_STORE) || (opc == OPC_BRANCH);
  endfunction

  // Instruction formats that read rs2 as a source operand.
  function automatic logic uses_rs2(input logic [6:0] opc);
    return (opc == OPC_R) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter: counts single-cycle increment pulses and sticks at
// all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  // Next count: advance on inc unless already at the ceiling.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register with asynchronous clear.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID-stage pipeline sequencing controller. Detects load-use hazards, data
// memory waits (freeze) and taken branches, and drives the PC / IF-ID / ID-EX
// enables, flush and bubble controls. Outputs are Mealy (state + inputs).
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int BRANCH_PENALTY = 2,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             ex_mem_read_en,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write_en,
  output logic             if_id_write_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_hold,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
);

  // Remaining-flush counter only needs to hold BRANCH_PENALTY-1.
  localparam int FC_W = (BRANCH_PENALTY > 2) ? $clog2(BRANCH_PENALTY) : 1;

  state_e          state_d, state_q;
  logic [FC_W-1:0] fcnt_d, fcnt_q;

  logic freeze;
  logic load_use;
  logic stall_inc, flush_inc, wait_inc;

  // A pending data-memory access stalls the whole pipeline.
  assign freeze = mem_req & ~mem_ready;

  assign load_use = ex_mem_read_en && (ex_rd != 5'd0) &&
                    ((uses_rs1(id_opcode) && (ex_rd == id_rs1)) ||
                     (uses_rs2(id_opcode) && (ex_rd == id_rs2)));

  // Next-state, flush countdown, pipeline controls and counter strobes.
  // NOTE: every signal gets a default before any branch so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d        = state_q;
    fcnt_d         = fcnt_q;
    pc_write_en    = 1'b0;
    if_id_write_en = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_bubble   = 1'b0;
    pipe_hold      = 1'b0;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;
    wait_inc       = 1'b0;

    if (rst) begin
      // All controls low while reset is asserted; registers clear async.
    end else if (freeze) begin
      pipe_hold = 1'b1;
      wait_inc  = 1'b1;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (ex_branch_taken) begin
            pc_write_en    = 1'b1;
            if_id_write_en = 1'b1;
            if_id_flush    = 1'b1;
            id_ex_bubble   = 1'b1;
            flush_inc      = 1'b1;
            if (BRANCH_PENALTY > 1) begin
              state_d = ST_FLUSH;
              fcnt_d  = FC_W'(BRANCH_PENALTY - 1);
            end
          end else if (load_use) begin
            id_ex_bubble = 1'b1;
            stall_inc    = 1'b1;
          end else begin
            pc_write_en    = 1'b1;
            if_id_write_en = 1'b1;
          end
        end
        ST_FLUSH: begin
          // Wrong-path instructions: branch and hazard inputs are ignored.
          pc_write_en    = 1'b1;
          if_id_write_en = 1'b1;
          if_id_flush    = 1'b1;
          id_ex_bubble   = 1'b1;
          flush_inc      = 1'b1;
          fcnt_d         = fcnt_q - FC_W'(1);
          if (fcnt_q == FC_W'(1)) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // FSM state and flush countdown registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .cnt (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_inc),
    .cnt (flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_wait_cnt (
    .clk (clk),
    .rst (rst),
    .inc (wait_inc),
    .cnt (wait_cnt)
  );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed testbench for hazard_stall_ctrl. Control outputs are compared as
// a packed vector {pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble,
// pipe_hold}. A second instance with CNT_W=4 shares the stimulus to check
// counter saturation.
module tb_hazard_stall_ctrl;
  import hazard_stall_ctrl_pkg::*;

  localparam logic [4:0] C_IDLE   = 5'b11000;
  localparam logic [4:0] C_STALL  = 5'b00010;
  localparam logic [4:0] C_FLUSH  = 5'b11110;
  localparam logic [4:0] C_FREEZE = 5'b00001;
  localparam logic [4:0] C_RESET  = 5'b00000;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  id_opcode;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        ex_mem_read_en, ex_branch_taken, mem_req, mem_ready;
  logic        pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, pipe_hold;
  logic [15:0] stall_cnt, flush_cnt, wait_cnt;
  logic        pc4, ifid4, flush4, bubble4, hold4;
  logic [3:0]  stall_cnt4, flush_cnt4, wait_cnt4;
  logic [4:0]  ctl;

  int checks = 0;
  int errors = 0;

  assign ctl = {pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, pipe_hold};

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.BRANCH_PENALTY(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_mem_read_en(ex_mem_read_en), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .pipe_hold(pipe_hold),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
  );

  hazard_stall_ctrl #(.BRANCH_PENALTY(2), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_mem_read_en(ex_mem_read_en), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write_en(pc4), .if_id_write_en(ifid4), .if_id_flush(flush4),
    .id_ex_bubble(bubble4), .pipe_hold(hold4),
    .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4), .wait_cnt(wait_cnt4)
  );

  // Advance one clock; inputs change and outputs are sampled well after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    id_opcode       = OPC_R;
    id_rs1          = 5'd1;
    id_rs2          = 5'd2;
    ex_mem_read_en  = 1'b0;
    ex_rd           = 5'd0;
    ex_branch_taken = 1'b0;
    mem_req         = 1'b0;
    mem_ready       = 1'b0;
  endtask

  task automatic set_load_use();
    id_opcode      = OPC_R;
    id_rs1         = 5'd1;
    id_rs2         = 5'd5;
    ex_mem_read_en = 1'b1;
    ex_rd          = 5'd5;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    #1;
    checks++;
    if (ctl !== C_RESET) begin
      errors++;
      $display("FAIL reset_ctl: got %b expected %b", ctl, C_RESET);
    end
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (ctl !== C_IDLE) begin
      errors++;
      $display("FAIL post_reset_idle: got %b expected %b", ctl, C_IDLE);
    end
    checks++;
    if ({stall_cnt, flush_cnt, wait_cnt} !== 48'd0) begin
      errors++;
      $display("FAIL reset_cnts: got %0d/%0d/%0d expected 0/0/0", stall_cnt, flush_cnt, wait_cnt);
    end
  endtask

  task automatic test_load_use();
    set_load_use();
    #1;
    checks++;
    if (ctl !== C_STALL) begin
      errors++;
      $display("FAIL load_use_ctl: got %b expected %b", ctl, C_STALL);
    end
    tick();
    set_idle();
    #1;
    checks++;
    if (ctl !== C_IDLE) begin
      errors++;
      $display("FAIL load_use_release: got %b expected %b", ctl, C_IDLE);
    end
    checks++;
    if (stall_cnt !== 16'd1) begin
      errors++;
      $display("FAIL load_use_cnt: got %0d expected 1", stall_cnt);
    end
  endtask

  task automatic test_no_stall();
    // Load to x0 never creates a hazard.
    ex_mem_read_en = 1'b1;
    ex_rd          = 5'd0;
    id_opcode      = OPC_R;
    id_rs1         = 5'd0;
    id_rs2         = 5'd0;
    #1;
    checks++;
    if (ctl !== C_IDLE) begin
      errors++;
      $display("FAIL no_stall_x0: got %b expected %b", ctl, C_IDLE);
    end
    tick();
    // A load in ID does not read rs2.
    id_opcode = OPC_LOAD;
    id_rs1    = 5'd3;
    id_rs2    = 5'd5;
    ex_rd     = 5'd5;
    #1;
    checks++;
    if (ctl !== C_IDLE) begin
      errors++;
      $display("FAIL no_stall_load_rs2: got %b expected %b", ctl, C_IDLE);
    end
    tick();
    // A store does read rs2.
    id_opcode = OPC_STORE;
    #1;
    checks++;
    if (ctl !== C_STALL) begin
      errors++;
      $display("FAIL store_rs2_stall: got %b expected %b", ctl, C_STALL);
    end
    tick();
    set_idle();
    #1;
    checks++;
    if (stall_cnt !== 16'd2) begin
      errors++;
      $display("FAIL no_stall_cnt: got %0d expected 2", stall_cnt);
    end
  endtask

  task automatic test_branch();
    ex_branch_taken = 1'b1;
    #1;
    checks++;
    if (ctl !== C_FLUSH) begin
      errors++;
      $display("FAIL branch_cycle1: got %b expected %b", ctl, C_FLUSH);
    end
    tick();
    ex_branch_taken = 1'b0;
    #1;
    checks++;
    if (ctl !== C_FLUSH) begin
      errors++;
      $display("FAIL branch_cycle2: got %b expected %b", ctl, C_FLUSH);
    end
    tick();
    checks++;
    if (ctl !== C_IDLE) begin
      errors++;
      $display("FAIL branch_back_to_run: got %b expected %b", ctl, C_IDLE);
    end
    checks++;
    if (flush_cnt !== 16'd2) begin
      errors++;
      $display("FAIL branch_flush_cnt: got %0d expected 2", flush_cnt);
    end
  endtask

  task automatic test_mem_wait();
    mem_req   = 1'b1;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl !== C_FREEZE) begin
        errors++;
        $display("FAIL mem_wait_cycle%0d: got %b expected %b", i, ctl, C_FREEZE);
      end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if (ctl !== C_IDLE) begin
      errors++;
      $display("FAIL mem_ready_resume: got %b expected %b", ctl, C_IDLE);
    end
    tick();
    set_idle();
    // mem_ready without a request is ignored.
    mem_ready = 1'b1;
    #1;
    checks++;
    if (ctl !== C_IDLE) begin
      errors++;
      $display("FAIL ready_no_req: got %b expected %b", ctl, C_IDLE);
    end
    tick();
    set_idle();
    checks++;
    if (wait_cnt !== 16'd3) begin
      errors++;
      $display("FAIL mem_wait_cnt: got %0d expected 3", wait_cnt);
    end
  endtask

  task automatic test_freeze_in_flush();
    ex_branch_taken = 1'b1;
    tick();
    ex_branch_taken = 1'b0;
    mem_req         = 1'b1;
    mem_ready       = 1'b0;
    #1;
    checks++;
    if (ctl !== C_FREEZE) begin
      errors++;
      $display("FAIL freeze_in_flush: got %b expected %b", ctl, C_FREEZE);
    end
    tick();
    tick();
    mem_ready = 1'b1;
    #1;
    checks++;
    if (ctl !== C_FLUSH) begin
      errors++;
      $display("FAIL flush_resumes: got %b expected %b", ctl, C_FLUSH);
    end
    tick();
    set_idle();
    #1;
    checks++;
    if (ctl !== C_IDLE) begin
      errors++;
      $display("FAIL flush_done_after_freeze: got %b expected %b", ctl, C_IDLE);
    end
    checks++;
    if (flush_cnt !== 16'd4 || wait_cnt !== 16'd5) begin
      errors++;
      $display("FAIL freeze_flush_cnts: got flush=%0d wait=%0d expected flush=4 wait=5", flush_cnt, wait_cnt);
    end
  endtask

  task automatic test_back_to_back();
    // Branch and load-use together: branch wins, then hazard ignored in FLUSH.
    set_load_use();
    ex_branch_taken = 1'b1;
    #1;
    checks++;
    if (ctl !== C_FLUSH) begin
      errors++;
      $display("FAIL branch_beats_load_use: got %b expected %b", ctl, C_FLUSH);
    end
    tick();
    ex_branch_taken = 1'b0;
    #1;
    checks++;
    if (ctl !== C_FLUSH) begin
      errors++;
      $display("FAIL flush_ignores_hazard: got %b expected %b", ctl, C_FLUSH);
    end
    tick();
    set_idle();
    #1;
    checks++;
    if (stall_cnt !== 16'd2 || flush_cnt !== 16'd6) begin
      errors++;
      $display("FAIL b2b_cnts: got stall=%0d flush=%0d expected stall=2 flush=6", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_reset_mid_flush();
    ex_branch_taken = 1'b1;
    tick();
    ex_branch_taken = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (ctl !== C_RESET) begin
      errors++;
      $display("FAIL reset_mid_flush_ctl: got %b expected %b", ctl, C_RESET);
    end
    checks++;
    if ({stall_cnt, flush_cnt, wait_cnt} !== 48'd0) begin
      errors++;
      $display("FAIL reset_mid_flush_cnts: got %0d/%0d/%0d expected 0/0/0", stall_cnt, flush_cnt, wait_cnt);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (ctl !== C_IDLE) begin
      errors++;
      $display("FAIL run_after_reset: got %b expected %b", ctl, C_IDLE);
    end
    tick();
    checks++;
    if (ctl !== C_IDLE || flush_cnt !== 16'd0) begin
      errors++;
      $display("FAIL run_after_reset2: got ctl=%b flush=%0d expected ctl=%b flush=0", ctl, flush_cnt, C_IDLE);
    end
  endtask

  task automatic test_saturation();
    set_load_use();
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14) begin
        checks++;
        if (stall_cnt4 !== 4'd14) begin
          errors++;
          $display("FAIL sat_count14: got %0d expected 14", stall_cnt4);
        end
      end
    end
    set_idle();
    #1;
    checks++;
    if (stall_cnt4 !== 4'd15) begin
      errors++;
      $display("FAIL sat_hold15: got %0d expected 15", stall_cnt4);
    end
    checks++;
    if (stall_cnt !== 16'd20) begin
      errors++;
      $display("FAIL wide_count20: got %0d expected 20", stall_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch();
    test_mem_wait();
    test_freeze_in_flush();
    test_back_to_back();
    test_reset_mid_flush();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
